// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store stage over a word-only data ram (optional LSU_MISALIGN_CHECK_EN)
module load_store_unit #(
    parameter int          WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_re,
    input  logic [31:0] ram_rd,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    output logic [29:0] ram_addr
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [29:0] addr_q, addr_d;

    logic [31:0] off;
    logic        f3_ok, range_err, misalign, req_err, is_half, is_word;
    logic [1:0]  lane_in;
    logic [4:0]  sh;
    logic [31:0] sh_rd, ld_data, mask, merged;

    assign off       = req_addr - BASE_ADDR;
    assign is_half   = req_funct3[1:0] == 2'b01;
    assign is_word   = req_funct3[1:0] == 2'b10;
    assign f3_ok     = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign range_err = (req_addr < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(WORDS));
`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign  = (is_half & off[0]) | (is_word & (|off[1:0]));
    assign lane_in   = off[1:0];
`else
    // Without the check, sub-word offsets are truncated so the access is naturally aligned.
    assign misalign  = 1'b0;
    assign lane_in   = is_word ? 2'b00 : is_half ? {off[1], 1'b0} : off[1:0];
`endif
    assign req_err   = !f3_ok | range_err | misalign;

    assign sh      = {lane_q, 3'b000};
    assign sh_rd   = ram_rd >> sh;
    assign ld_data = funct3_q[1] ? ram_rd
                   : funct3_q[0] ? {{16{!funct3_q[2] & sh_rd[15]}}, sh_rd[15:0]}
                   : {{24{!funct3_q[2] & sh_rd[7]}}, sh_rd[7:0]};
    // wd_q holds the raw store data until the RMW read replaces it with the merged word.
    assign mask    = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    assign merged  = (ram_rd & ~(mask << sh)) | ((wd_q & mask) << sh);

    assign req_ready  = !rst && state_q == S_IDLE;
    assign resp_valid = !rst && state_q == S_RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_re     = !rst && (state_q == S_LOAD || state_q == S_RMW_RD);
    assign ram_we     = !rst && state_q == S_WRITE;
    assign ram_wd     = wd_q;
    assign ram_addr   = addr_q;

    // Next-state logic: latch the request on accept and sequence the ram accesses.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        wd_d     = wd_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                funct3_d = req_funct3;
                lane_d   = lane_in;
                wd_d     = req_wdata;
                rdata_d  = 32'h0;
                err_d    = req_err;
                addr_d   = off[31:2];
                state_d  = req_err ? S_RESP : !req_we ? S_LOAD : is_word ? S_WRITE : S_RMW_RD;
            end
            S_LOAD: begin
                rdata_d = ld_data;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                wd_d    = merged;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset back to an idle, quiet interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'b000;
            lane_q   <= 2'b00;
            wd_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            addr_q   <= 30'h0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            wd_q     <= wd_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
        end
    end
endmodule
